// File: rtl/fft_pingpong_ram_if.sv
// Bus bundle for the FFT ping-pong RAM: the two write ports, the two read
// ports, the bank swap control and the pass-tracking status outputs.
// The master modport drives the RAM; the slave modport is the RAM itself.
interface fft_pingpong_ram_if #(
  parameter int width = 64,
  parameter int log_s = 10
);

  // Write side: both ports commit on the same edge when wr_en is high.
  logic             wr_en;
  logic [log_s-1:0] wr_addr_0;
  logic [log_s-1:0] wr_addr_1;
  logic [width-1:0] wr_data_0;
  logic [width-1:0] wr_data_1;

  // Read side: registered data, one cycle after rd_en.
  logic             rd_en;
  logic [log_s-1:0] rd_addr_0;
  logic [log_s-1:0] rd_addr_1;
  logic [width-1:0] rd_data_0;
  logic [width-1:0] rd_data_1;
  logic             rd_valid;

  // Bank role exchange and pass tracking.
  logic             swap;
  logic             bank_sel;
  logic [log_s-1:0] stage_cnt;
  logic             pass_done;

  modport master (
    output wr_en, wr_addr_0, wr_addr_1, wr_data_0, wr_data_1,
    output rd_en, rd_addr_0, rd_addr_1,
    output swap,
    input  rd_data_0, rd_data_1, rd_valid,
    input  bank_sel, stage_cnt, pass_done
  );

  modport slave (
    input  wr_en, wr_addr_0, wr_addr_1, wr_data_0, wr_data_1,
    input  rd_en, rd_addr_0, rd_addr_1,
    input  swap,
    output rd_data_0, rd_data_1, rd_valid,
    output bank_sel, stage_cnt, pass_done
  );

endinterface

// File: rtl/fft_pingpong_ram.sv
// Ping-pong sample RAM for an iterative FFT.
// Two banks (A when bank_sel=0, B when bank_sel=1), each size x width with
// two write and two read ports. One bank is written while the other is read;
// a swap exchanges the roles, and stage_cnt tracks swaps within one pass of
// 'stages' swaps, pulsing pass_done on the swap that completes a pass.
// Optional feature: define FFT_RAM_BITREV_EN to bit-reverse the write
// addresses (read addresses are never reversed).
// Memory contents are deliberately left untouched by reset.
module fft_pingpong_ram #(
  parameter int width  = 64,
  parameter int size   = 1024,
  parameter int log_s  = 10,
  parameter int stages = 10
) (
  input logic            clk,
  input logic            rst,
  fft_pingpong_ram_if.slave bus
);

  // Last stage index of a pass and the bank depth as address-sized constants.
  localparam logic [log_s-1:0] LastStage = log_s'(stages - 1);
  localparam logic [log_s:0]   SizeL     = (log_s + 1)'(size);

  // Storage for both banks.
  logic [width-1:0] bankA [size];
  logic [width-1:0] bankB [size];

  // Control and output registers.
  logic             bankSel_q,  bankSel_d;
  logic [log_s-1:0] stageCnt_q, stageCnt_d;
  logic             passDone_q, passDone_d;
  logic             rdValid_q,  rdValid_d;
  logic [width-1:0] rdData0_q,  rdData0_d;
  logic [width-1:0] rdData1_q,  rdData1_d;

  // Effective write addresses after optional bit reversal.
  logic [log_s-1:0] wrIdx0;
  logic [log_s-1:0] wrIdx1;

  // Address range qualifiers; only meaningful when size < 2**log_s.
  logic             wrOk0, wrOk1;
  logic             rdOk0, rdOk1;

  // Raw words fetched from the current read bank.
  logic [width-1:0] readWord0;
  logic [width-1:0] readWord1;

`ifdef FFT_RAM_BITREV_EN
  // Mirror the write address bits so a natural-order producer lands in
  // bit-reversed order, ready for the in-place butterfly passes.
  always_comb begin
    wrIdx0 = '0;
    wrIdx1 = '0;
    for (int i = 0; i < log_s; i++) begin
      wrIdx0[i] = bus.wr_addr_0[log_s-1-i];
      wrIdx1[i] = bus.wr_addr_1[log_s-1-i];
    end
  end
`else
  // Without reversal the write addresses go straight to the banks.
  always_comb begin
    wrIdx0 = bus.wr_addr_0;
    wrIdx1 = bus.wr_addr_1;
  end
`endif

  // Flag addresses that fall outside a non-power-of-two bank.
  always_comb begin
    wrOk0 = ({1'b0, wrIdx0} < SizeL);
    wrOk1 = ({1'b0, wrIdx1} < SizeL);
    rdOk0 = ({1'b0, bus.rd_addr_0} < SizeL);
    rdOk1 = ({1'b0, bus.rd_addr_1} < SizeL);
  end

  // Fetch from the bank opposite the write bank; out-of-range reads give 0.
  always_comb begin
    readWord0 = '0;
    readWord1 = '0;
    if (rdOk0) begin
      readWord0 = bankSel_q ? bankA[bus.rd_addr_0] : bankB[bus.rd_addr_0];
    end
    if (rdOk1) begin
      readWord1 = bankSel_q ? bankA[bus.rd_addr_1] : bankB[bus.rd_addr_1];
    end
  end

  // Commit both write ports into the current write bank. Port 1 is written
  // after port 0 so it wins on an address collision. Reset drops the write
  // but does not clear stored data.
  always_ff @(posedge clk) begin
    if (!rst && bus.wr_en) begin
      if (wrOk0) begin
        if (bankSel_q) begin
          bankB[wrIdx0] <= bus.wr_data_0;
        end else begin
          bankA[wrIdx0] <= bus.wr_data_0;
        end
      end
      if (wrOk1) begin
        if (bankSel_q) begin
          bankB[wrIdx1] <= bus.wr_data_1;
        end else begin
          bankA[wrIdx1] <= bus.wr_data_1;
        end
      end
    end
  end

  // Next-state for read data, bank role and pass tracking. Reads and writes
  // in a swap cycle still see the pre-swap roles because they use bankSel_q.
  always_comb begin
    bankSel_d  = bankSel_q;
    stageCnt_d = stageCnt_q;
    passDone_d = 1'b0;
    rdValid_d  = bus.rd_en;
    rdData0_d  = rdData0_q;
    rdData1_d  = rdData1_q;
    if (bus.rd_en) begin
      rdData0_d = readWord0;
      rdData1_d = readWord1;
    end
    if (bus.swap) begin
      bankSel_d = ~bankSel_q;
      if (stageCnt_q == LastStage) begin
        stageCnt_d = '0;
        passDone_d = 1'b1;
      end else begin
        stageCnt_d = stageCnt_q + log_s'(1);
      end
    end
  end

  // Register control state; reset abandons any pass in progress silently.
  always_ff @(posedge clk) begin
    if (rst) begin
      bankSel_q  <= 1'b0;
      stageCnt_q <= '0;
      passDone_q <= 1'b0;
      rdValid_q  <= 1'b0;
      rdData0_q  <= '0;
      rdData1_q  <= '0;
    end else begin
      bankSel_q  <= bankSel_d;
      stageCnt_q <= stageCnt_d;
      passDone_q <= passDone_d;
      rdValid_q  <= rdValid_d;
      rdData0_q  <= rdData0_d;
      rdData1_q  <= rdData1_d;
    end
  end

  assign bus.bank_sel  = bankSel_q;
  assign bus.stage_cnt = stageCnt_q;
  assign bus.pass_done = passDone_q;
  assign bus.rd_valid  = rdValid_q;
  assign bus.rd_data_0 = rdData0_q;
  assign bus.rd_data_1 = rdData1_q;

endmodule
